ntt_stage_engine: RTL

Parametrised, self-sequencing NTT butterfly core that runs one complete NTT/INTT stage over a bank of coefficient pairs after a single `start` pulse. It is the successor of the fixed two-butterfly core. Lane count, coefficient width, modulus, memory depth and twiddle addressing are generic. It adds an internal address sequencer, forward (Cooley-Tukey) and inverse (Gentleman-Sande) modes, and an output valid/address stream. It sits between a core's coefficient RAM and twiddle ROM (read side) and the stage write-back logic (write side).

---
 rtl/ntt_stage_engine.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ntt_stage_engine.sv
// Self-sequencing NTT butterfly stage over a coefficient bank. Reads issue one per cycle; each word's results appear 4 cycles after its read.
// No backpressure: once started, the read and result streams run one word per cycle until the stage drains.
module ntt_stage_engine #(
  parameter int          WIDTH     = 30,
  parameter int unsigned MODULUS   = 1073479681,
  parameter int          LANES     = 2,
  parameter int          ADDR_W    = 9,
  parameter int          TW_ADDR_W = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         inverse,
  input  logic [ADDR_W:0]              count,
  input  logic [TW_ADDR_W-1:0]         tw_base,
  input  logic [TW_ADDR_W-1:0]         tw_stride,
  output logic                         busy,
  output logic                         done,
  output logic                         mem_rd_en,
  output logic [ADDR_W-1:0]            mem_rd_addr,
  input  logic [2*LANES*WIDTH-1:0]     mem_rd_data,
  output logic [LANES*TW_ADDR_W-1:0]   tw_addr,
  input  logic [LANES*WIDTH-1:0]       tw_data,
  output logic                         out_valid,
  output logic [ADDR_W-1:0]            out_addr,
  output logic [2*LANES*WIDTH-1:0]     out_data
);

  localparam int PW = 2 * WIDTH;
  localparam int NW = 4 * WIDTH;
  localparam logic [WIDTH-1:0] Q  = WIDTH'(MODULUS);
  localparam logic [NW-1:0]    QN = NW'(MODULUS);
  // Barrett constant floor(2^(2*WIDTH) / q)
  localparam logic [NW-1:0]    BM = (NW'(1) << PW) / QN;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    if (x >= y) return x - y;
    return x + (Q - y);
  endfunction

  function automatic logic [PW-1:0] mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return PW'(x) * PW'(y);
  endfunction

  // Input is a product of two residues (< q^2), so the Barrett estimate is off by at most 2q.
  function automatic logic [WIDTH-1:0] mod_reduce(input logic [PW-1:0] x);
    logic [NW-1:0] t;
    t = (NW'(x) * BM) >> PW;
    t = NW'(x) - t * QN;
    if (t >= QN) t = t - QN;
    if (t >= QN) t = t - QN;
    return t[WIDTH-1:0];
  endfunction

  state_t               state;
  logic                 inv;
  logic [ADDR_W:0]      k, cnt;
  logic [TW_ADDR_W-1:0] acc, stride;
  logic                 v0, v1, v2;
  logic [ADDR_W-1:0]    a0, a1, a2;
  logic                 pipe_empty;

  assign pipe_empty = !mem_rd_en && !v0 && !v1 && !v2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      inv         <= 1'b0;
      k           <= '0;
      cnt         <= '0;
      acc         <= '0;
      stride      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      tw_addr     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            inv    <= inverse;
            cnt    <= count;
            stride <= tw_stride;
            busy   <= 1'b1;
            if (count != '0) begin
              state       <= RUN;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= '0;
              k           <= (ADDR_W+1)'(1);
              acc         <= tw_base + tw_stride;
              for (int l = 0; l < LANES; l++)
                tw_addr[l*TW_ADDR_W +: TW_ADDR_W] <= tw_base + TW_ADDR_W'(l);
            end else begin
              state <= DRAIN;
            end
          end
        end
        RUN: begin
          if (k == cnt) begin
            mem_rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            mem_rd_addr <= k[ADDR_W-1:0];
            k           <= k + (ADDR_W+1)'(1);
            acc         <= acc + stride;
            for (int l = 0; l < LANES; l++)
              tw_addr[l*TW_ADDR_W +: TW_ADDR_W] <= acc + TW_ADDR_W'(l);
          end
        end
        DRAIN: begin
          // Final result may still be on the output this cycle; done lands the cycle after.
          if (done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (pipe_empty) begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [WIDTH-1:0] in_a [LANES];
  logic [WIDTH-1:0] in_b [LANES];
  logic [WIDTH-1:0] in_w [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      in_a[l] = mem_rd_data[2*l*WIDTH +: WIDTH];
      in_b[l] = mem_rd_data[(2*l+1)*WIDTH +: WIDTH];
      in_w[l] = tw_data[l*WIDTH +: WIDTH];
    end
  end

  logic [PW-1:0]    s1_p [LANES];
  logic [WIDTH-1:0] s1_u [LANES];
  logic [WIDTH-1:0] s1_v [LANES];
  logic [WIDTH-1:0] s1_w [LANES];
  logic [PW-1:0]    s2_x [LANES];
  logic [WIDTH-1:0] s2_u [LANES];

  // CT: product, reduce, add/sub.  GS: sum/diff, diff*w, reduce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      a0        <= '0;
      a1        <= '0;
      a2        <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      for (int l = 0; l < LANES; l++) begin
        s1_p[l] <= '0;
        s1_u[l] <= '0;
        s1_v[l] <= '0;
        s1_w[l] <= '0;
        s2_x[l] <= '0;
        s2_u[l] <= '0;
      end
    end else begin
      v0        <= mem_rd_en;
      a0        <= mem_rd_addr;
      v1        <= v0;
      a1        <= a0;
      v2        <= v1;
      a2        <= a1;
      out_valid <= v2;
      out_addr  <= a2;
      for (int l = 0; l < LANES; l++) begin
        s1_p[l] <= mul(in_w[l], in_b[l]);
        s1_u[l] <= inv ? mod_add(in_a[l], in_b[l]) : in_a[l];
        s1_v[l] <= mod_sub(in_a[l], in_b[l]);
        s1_w[l] <= in_w[l];

        s2_x[l] <= inv ? mul(s1_v[l], s1_w[l]) : PW'(mod_reduce(s1_p[l]));
        s2_u[l] <= s1_u[l];

        out_data[2*l*WIDTH +: WIDTH]     <= inv ? s2_u[l] : mod_add(s2_u[l], s2_x[l][WIDTH-1:0]);
        out_data[(2*l+1)*WIDTH +: WIDTH] <= inv ? mod_reduce(s2_x[l]) : mod_sub(s2_u[l], s2_x[l][WIDTH-1:0]);
      end
    end
  end

endmodule
